// File: rtl/i2c_write_queue.sv
// i2c_write_queue
// Write-command queue and issue sequencer that sits in front of a
// single-byte I2C master. System logic pushes {slave address, data byte}
// entries into a circular FIFO. The sequencer issues one entry at a time
// through the master's start/busy handshake, then waits out a bus-idle gap
// before it issues the next entry. Failed transactions are counted.
//
// Ports
//   i_clk, i_rst               clock; asynchronous active-high reset
//   i_push, i_push_addr,
//   i_push_byte                enqueue one {addr, byte} entry
//   i_flush                    drop every queued entry (in-flight one unaffected)
//   o_full, o_empty, o_level   FIFO status
//   o_overflow                 sticky flag: a push arrived while full
//   o_slave_addr, o_wr_byte,
//   o_wr_start                 command to the master (start is a 1-cycle pulse)
//   i_busy, i_error            status from the master
//   o_done                     1-cycle pulse per finished transaction
//   o_err_count                saturating count of failed transactions
//   o_idle                     sequencer idle and queue empty
module i2c_write_queue #(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 100,
    parameter int ACCEPT_TIMEOUT = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [6:0]                 i_push_addr,
    input  logic [7:0]                 i_push_byte,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [6:0]                 o_slave_addr,
    output logic [7:0]                 o_wr_byte,
    output logic                       o_wr_start,
    input  logic                       i_busy,
    input  logic                       i_error,
    output logic                       o_done,
    output logic [7:0]                 o_err_count,
    output logic                       o_idle
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int CMAX = (GAP_CYCLES > ACCEPT_TIMEOUT) ? GAP_CYCLES : ACCEPT_TIMEOUT;
    // One counter serves both the accept timeout and the idle gap.
    localparam int CW   = $clog2(CMAX + 2);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_ACCEPT = 3'd2,
        ST_WAIT_DONE   = 3'd3,
        ST_GAP         = 3'd4
    } state_t;

    logic [14:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_flag_q, err_flag_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          done_q, done_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    byte_q, byte_d;

    logic          empty_s, full_s, push_ok_s, pop_s, fail_s;
    logic [14:0]   head_s;

    // The extra pointer MSB tells a full ring apart from an empty one.
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Flush wins over a simultaneous push, and a push into a full queue is
    // dropped even if a pop frees a slot in the same cycle.
    assign push_ok_s = i_push && !full_s && !i_flush;
    assign pop_s     = (state_q == ST_IDLE) && !empty_s && !i_busy;
    assign head_s    = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO pointer and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (i_flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (i_push && full_s && !i_flush) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Sequencer next-state, counters and command outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        byte_d     = byte_q;
        fail_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    addr_d  = head_s[14:8];
                    byte_d  = head_s[7:0];
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d      = '0;
                err_flag_d = 1'b0;
                state_d    = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (i_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CW'(ACCEPT_TIMEOUT - 1)) begin
                    // Master never accepted the start: count it as a failure.
                    fail_s  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (i_busy) begin
                    err_flag_d = err_flag_q | i_error;
                end else begin
                    fail_s  = err_flag_q | i_error;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // GAP lasts GAP_CYCLES+1 cycles, so the next start rises
                // GAP_CYCLES+2 cycles after done.
                if (cnt_q == CW'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fail_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate access
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {i_push_addr, i_push_byte};
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= 8'd0;
            done_q     <= 1'b0;
            addr_q     <= 7'd0;
            byte_q     <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
        end
    end

    assign o_empty      = empty_s;
    assign o_full       = full_s;
    assign o_level      = wr_ptr_q - rd_ptr_q;
    assign o_overflow   = overflow_q;
    assign o_slave_addr = addr_q;
    assign o_wr_byte    = byte_q;
    // Decoded from the state register, so it drops as soon as reset asserts.
    assign o_wr_start   = (state_q == ST_ISSUE);
    assign o_done       = done_q;
    assign o_err_count  = err_cnt_q;
    assign o_idle       = (state_q == ST_IDLE) && empty_s;

endmodule

// File: doc/i2c_write_queue.md
# i2c_write_queue

Command queue and issue sequencer directly upstream of `i2c_master_single_byte`. System logic pushes {7-bit slave address, data byte} write entries into an internal FIFO. The sequencer drains one entry at a time into the single-byte master through its `i_wr_start`/`o_busy` handshake, then waits a programmable bus-idle gap before issuing the next. It also counts failed transactions.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `GAP_CYCLES`, 100, idle clocks inserted after each transaction; 0 means no gap.
- `ACCEPT_TIMEOUT`, 8, clocks to wait for the master's busy to rise after a start.

- `i_clk`  in  1  single clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_push`  in  1  write one entry when FIFO not full.
- `i_push_addr`  in  7  slave address of the pushed entry.
- `i_push_byte`  in  8  data byte of the pushed entry.
- `i_flush`  in  1  discard all queued (not in-flight) entries.
- `o_full`, `o_empty`  out  1  FIFO status.
- `o_level`  out  clog2(DEPTH)+1  entries queued.
- `o_overflow`  out  1  sticky; set by a push while full.
- `o_slave_addr`  out  7  to master `i_slave_addr`.
- `o_wr_byte`  out  8  to master `i_wr_byte`.
- `o_wr_start`  out  1  to master `i_wr_start`; one-cycle pulse.
- `i_busy`  in  1  from master `o_busy`.
- `i_error`  in  1  from master `o_error`.
- `o_done`  out  1  one-cycle pulse per completed transaction, including failed ones.
- `o_err_count`  out  8  saturating count of failed transactions.
- `o_idle`  out  1  FSM in IDLE and FIFO empty.

## Operation
- Reset values:
  - FIFO empty; `o_empty`=1, `o_full`=0, `o_level`=0, `o_overflow`=0.
  - `o_slave_addr`=0, `o_wr_byte`=0, `o_wr_start`=0.
  - `o_done`=0, `o_err_count`=0, `o_idle`=1.
  - State is IDLE; all counters are 0.
- FIFO:
  - Circular buffer with read/write pointers of width clog2(DEPTH)+1; the MSB distinguishes full from empty.
  - A push while full is dropped and sets `o_overflow`. This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle, with the FIFO not full, leaves `o_level` unchanged.
  - `i_flush` sets read pointer = write pointer. Flush takes priority over a push in the same cycle; that push is dropped and `o_overflow` is not set.
- State machine:
  - IDLE: if FIFO not empty and `i_busy`=0, load the head entry into `o_slave_addr`/`o_wr_byte`, pop, and go to ISSUE.
  - ISSUE: `o_wr_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT_ACCEPT.
  - WAIT_ACCEPT:
    - If `i_busy`=1, go to WAIT_DONE.
    - Otherwise increment the counter. When it reaches ACCEPT_TIMEOUT, the transaction has failed: increment the error count, pulse `o_done`, and go to GAP.
  - WAIT_DONE:
    - Latch a per-transaction error flag if `i_error`=1 in any cycle.
    - When `i_busy`=0, pulse `o_done`; if the flag is set, increment `o_err_count`. Go to GAP.
  - GAP: count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, go to IDLE on the next edge.
- `o_slave_addr`/`o_wr_byte` hold stable from ISSUE until the next load.
- `o_err_count` saturates at 255.
- `o_idle` = (state==IDLE) && `o_empty`.
- `i_flush` does not affect the in-flight transaction.

## Timing
- Push to start latency:
  - A push is sampled on edge N, and `o_empty` falls after edge N.
  - On edge N+1, IDLE pops the entry, and `o_wr_start` is high from edge N+1 to edge N+2.
  - The master samples the start on edge N+2.
- `o_wr_start` is a decode of the registered state, so it is glitch-free and never longer than 1 cycle.
- `i_busy` is expected high at edge N+3. The timeout counts from edge N+2.
- `o_done` is high for the single cycle after the edge where `i_busy`=0 is seen in WAIT_DONE.
- Back-to-back entries: the next `o_wr_start` rises GAP_CYCLES+2 cycles after `o_done` rises.
- Reset asserted mid-transaction:
  - All state clears immediately, and queued entries are lost.
  - `o_wr_start` drops asynchronously.
  - The master is reset by the same `i_rst`.

## Test plan
- Single entry, no error:
  - Stimulus: push addr 0x3C, byte 0xA5; master model raises busy 1 cycle after the start and holds it 40 cycles.
  - Required: one `o_wr_start` pulse with `o_slave_addr`=0x3C and `o_wr_byte`=0xA5; `o_done` fires once; `o_err_count`=0; `o_idle` returns to 1 after GAP_CYCLES.
- Queue fill:
  - Stimulus: 17 pushes with DEPTH=16 while the master is held busy.
  - Required: `o_full`=1 and `o_level`=16 after the 16th push; the 17th push is dropped and `o_overflow`=1. The entries then drain in push order, and the 17th never issues.
- Error path:
  - Stimulus: master model pulses `i_error` for 1 cycle during busy, for 3 of 5 transactions.
  - Required: 5 `o_done` pulses; `o_err_count`=3.
- Accept timeout:
  - Stimulus: master model never raises busy.
  - Required: `o_done` pulses 8 cycles after the start cycle, `o_err_count` increments, and the next entry issues after the gap.
- Flush and simultaneous events:
  - Stimulus: queue 4 entries, then assert `i_flush` together with a push during WAIT_DONE.
  - Required: the in-flight transaction completes; `o_level`=0; that push is dropped; `o_overflow` stays 0; no further starts.
- Reset mid-operation:
  - Stimulus: assert `i_rst` during WAIT_DONE with 3 entries queued.
  - Required: all outputs immediately at their reset values; no `o_wr_start` after release until a new push.
